// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP with a registered response.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req0_ci,
    input  logic       req1_ci,
    input  logic [2:0] req0_func,
    input  logic [2:0] req1_func,
    output logic [7:0] alu_inputA,
    output logic [7:0] alu_inputB,
    output logic       alu_carryIn,
    output logic [2:0] alu_func,
    input  logic [7:0] alu_result,
    input  logic       alu_carryOut,
    input  logic       alu_zero,
    input  logic       alu_negetive,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [7:0] resp_result,
    output logic       resp_co,
    output logic       resp_z,
    output logic       resp_n
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    state_t     next_state;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_ci;
    logic [2:0] op_func;
    logic       op_id;
    logic [7:0] res_result;
    logic       res_co;
    logic       res_z;
    logic       res_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (req0_valid || req1_valid) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready is gated by rst so nothing looks accepted while reset is held.
    always_comb begin
        accept = 1'b0;
        grant  = 1'b0;
        if (state == IDLE && !rst) begin
            accept = req0_valid || req1_valid;
            grant  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        end
    end

    assign req0_ready  = accept & ~grant;
    assign req1_ready  = accept & grant;
    assign resp_valid  = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            op_id      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_ci      <= 1'b0;
            op_func    <= '0;
            res_result <= '0;
            res_co     <= 1'b0;
            res_z      <= 1'b0;
            res_n      <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                op_id      <= grant;
                op_a       <= grant ? req1_a    : req0_a;
                op_b       <= grant ? req1_b    : req0_b;
                op_ci      <= grant ? req1_ci   : req0_ci;
                op_func    <= grant ? req1_func : req0_func;
            end
            if (state == EXEC) begin
                res_result <= alu_result;
                res_co     <= alu_carryOut;
                res_z      <= alu_zero;
                res_n      <= alu_negetive;
            end
        end
    end

    assign alu_inputA  = op_a;
    assign alu_inputB  = op_b;
    assign alu_carryIn = op_ci;
    assign alu_func    = op_func;
    assign resp_id     = op_id;
    assign resp_result = res_result;
    assign resp_co     = res_co;
    assign resp_z      = res_z;
    assign resp_n      = res_n;

endmodule
